hazard_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage core. Drives Stall/Flush of the IF/ID

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// The pipeline (master) presents the ID/EX-stage status and receives the sequencing controls.
// The controller (slave) consumes that status and drives stall, flush and the MUL/DIV status.
interface hazard_ctrl_if;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_uses_rs;
    logic       ID_uses_rt;
    logic       EX_MemRead;
    logic [4:0] EX_Wr_reg;
    logic       ID_Branch_likely;
    logic       ID_Branch_taken;
    logic       ID_MulDiv_start;
    logic       ID_MulDiv_is_div;
    logic       ID_HiLo_access;
    logic       EX_Exception;
    logic       Stall;
    logic       IF_Flush;
    logic       ID_EX_Flush;
    logic       MulDiv_busy;
    logic       MulDiv_done;

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_MemRead, EX_Wr_reg,
               ID_Branch_likely, ID_Branch_taken, ID_MulDiv_start, ID_MulDiv_is_div,
               ID_HiLo_access, EX_Exception,
        input  Stall, IF_Flush, ID_EX_Flush, MulDiv_busy, MulDiv_done
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_MemRead, EX_Wr_reg,
               ID_Branch_likely, ID_Branch_taken, ID_MulDiv_start, ID_MulDiv_is_div,
               ID_HiLo_access, EX_Exception,
        output Stall, IF_Flush, ID_EX_Flush, MulDiv_busy, MulDiv_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Combines load-use detection, branch-likely annulment and exception flush, and owns
// the multi-cycle HI/LO (MUL/DIV) occupancy FSM.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_busy;
    logic w_done;
    logic w_load_use;
    logic w_md_hazard;
    logic w_stall_raw;
    logic w_issue;
    logic w_stall;
    logic w_if_flush;
    logic w_id_ex_flush;

    assign w_busy = (r_state == BUSY);
    assign w_done = w_busy && (r_cnt == '0);

    assign w_load_use = hz.EX_MemRead && (hz.EX_Wr_reg != 5'd0) &&
                        ((hz.ID_uses_rs && (hz.ID_rs == hz.EX_Wr_reg)) ||
                         (hz.ID_uses_rt && (hz.ID_rt == hz.EX_Wr_reg)));

    // HI/LO is forwarded on the done cycle, so that cycle never stalls.
    assign w_md_hazard = w_busy && !w_done && (hz.ID_MulDiv_start || hz.ID_HiLo_access);
    assign w_stall_raw = w_load_use || w_md_hazard;

    // Issue is possible from IDLE or on the done cycle (back-to-back reload).
    assign w_issue = (!w_busy || w_done) && hz.ID_MulDiv_start &&
                     !w_stall_raw && !hz.EX_Exception;

    // State and occupancy counter register; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: load on issue, count down while busy, drop to IDLE after the last cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_issue) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = hz.ID_MulDiv_is_div ? DIV_LOAD : MUL_LOAD;
        end else if (r_state == BUSY) begin
            if (r_cnt == '0) begin
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    // Sequencing controls: exception > stall bubble > branch-likely annul; all off in reset.
    always_comb begin
        w_stall       = 1'b0;
        w_if_flush    = 1'b0;
        w_id_ex_flush = 1'b0;
        if (reset_n) begin
            if (hz.EX_Exception) begin
                w_if_flush    = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_stall_raw) begin
                w_stall       = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (hz.ID_Branch_likely && !hz.ID_Branch_taken) begin
                w_if_flush    = 1'b1;
            end
        end
    end

    assign hz.Stall       = w_stall;
    assign hz.IF_Flush    = w_if_flush;
    assign hz.ID_EX_Flush = w_id_ex_flush;
    assign hz.MulDiv_busy = w_busy;
    assign hz.MulDiv_done = w_done;

endmodule
